// File: rtl/rr_mux_n.sv
// N-input round-robin / fixed-priority multiplexer with a registered output
// slot; one word per cycle when the consumer keeps up.
module rr_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;

    logic              load_en;
    logic              found;
    logic [SEL_W-1:0]  gnt_idx;
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  sel_data;
    logic [SEL_W:0]    sum;
    logic [SEL_W-1:0]  idx;

    // Arbiter: search order starts at last_grant+1 (round-robin) or 0 (fixed)
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum = {1'b0, last_grant_q} + (SEL_W+1)'(k + 1);
            if (sum >= (SEL_W+1)'(NUM_IN)) begin
                sum = sum - (SEL_W+1)'(NUM_IN);
            end
            idx = mode ? SEL_W'(k) : sum[SEL_W-1:0];
            if (!found && in_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // One-hot grant and AND-OR data select so unselected channels are masked
    always_comb begin
        grant    = '0;
        sel_data = '0;
        if (found) begin
            grant[gnt_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept a new word when the slot is empty or being drained this cycle
    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = (load_en && !reset) ? grant : '0;
    end

    // Next-state for the output slot and round-robin pointer
    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (found) begin
                out_data_d   = sel_data;
                out_sel_d    = gnt_idx;
                out_valid_d  = 1'b1;
                last_grant_d = gnt_idx;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    // State registers; reset empties the slot and points the search at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of each channel.
REQ-002 Parameter NUM_IN, default 16, sets the number of input channels; legal range 2..32.
REQ-003 Parameter SEL_W, default 4, sets the width of the channel index and SHALL equal ceil(log2(NUM_IN)).
REQ-004 Port clock, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit, is an asynchronous active-high reset.
REQ-006 Port mode, input, 1 bit, selects arbitration: 0 is round-robin, 1 is fixed priority (lowest index wins).
REQ-007 Port in_data, input, NUM_IN*WIDTH bits, carries channel i in bits [i*WIDTH +: WIDTH].
REQ-008 Port in_valid, input, NUM_IN bits; bit i high means channel i offers a word.
REQ-009 Port in_ready, output, NUM_IN bits; bit i high means channel i's word is accepted this cycle.
REQ-010 Port out_data, output, WIDTH bits, is the registered selected word.
REQ-011 Port out_sel, output, SEL_W bits, is the registered index of the channel that supplied out_data.
REQ-012 Port out_valid, output, 1 bit, is high while out_data/out_sel hold an undelivered word.
REQ-013 Port out_ready, input, 1 bit; the consumer accepts the word when out_valid and out_ready are both high.

Function
REQ-014 A transfer on channel i SHALL occur exactly when in_valid[i] and in_ready[i] are both high at a rising clock edge.
REQ-015 load_en SHALL be high when out_valid is 0, or when out_valid and out_ready are both 1.
REQ-016 At most one in_ready bit SHALL be high in any cycle, and in_ready[i] SHALL equal load_en AND grant[i].
REQ-017 grant SHALL be one-hot over the valid requesters when any in_valid bit is high, and all-zero otherwise.
REQ-018 Round-robin mode: grant SHALL go to the first valid channel found searching from index last_grant+1 upward, wrapping from NUM_IN-1 to 0.
REQ-019 Fixed-priority mode: grant SHALL go to the lowest-index valid channel, regardless of last_grant.
REQ-020 On a transfer from channel g, the next edge SHALL load out_data=in_data[g], out_sel=g, out_valid=1 and last_grant=g (in either mode).
REQ-021 Latency from input transfer to out_valid SHALL be 1 cycle.
REQ-022 Sustained throughput SHALL be 1 word per cycle while out_ready=1 and any in_valid is high.
REQ-023 If out_valid=1 and out_ready=0, out_data and out_sel SHALL hold, and all in_ready bits SHALL be 0.
REQ-024 If out_valid and out_ready are both 1 with no in_valid bit high, out_valid SHALL clear at the next edge; out_data and out_sel SHALL hold their last values.
REQ-025 Simultaneous drain and load SHALL replace the register contents without a bubble cycle.
REQ-026 A change of mode SHALL take effect at the next arbitration decision; no in-flight word is altered.
REQ-027 in_valid bits whose index is NUM_IN or higher do not exist; index wrap SHALL use NUM_IN, not 2^SEL_W.
REQ-028 An unselected channel's in_data SHALL never affect any output.

Reset
REQ-029 While reset=1, regardless of clock: out_valid=0, out_data=0, out_sel=0, last_grant=NUM_IN-1, and in_ready=0.
REQ-030 After reset deasserts, the first round-robin grant SHALL search from channel 0.
REQ-031 Reset asserted mid-transfer SHALL discard the held word; no partial state is retained.

Verification
REQ-032 Reset, then in_valid=16'hFFFF, out_ready=1, mode=0 for 17 cycles -> out_sel sequence 0,1,...,15,0; out_valid=1 from cycle 2.
REQ-033 mode=1, in_valid=16'h0110, out_ready=1 -> out_sel stays 4 every cycle; channel 8 is never granted.
REQ-034 Word 0xDEADBEEF on ch3 loaded, then out_ready=0 for 5 cycles with in_valid=16'hFFFF -> out_data holds 0xDEADBEEF, out_sel=3, in_ready=0 throughout.
REQ-035 last_grant=15 and only ch15 and ch0 valid, mode=0 -> ch0 is granted next (wrap-around), then ch15.
REQ-036 Reset pulsed while out_valid=1 with continuous traffic -> out_valid=0 and out_data=0 immediately; first grant after release is the lowest valid channel at or above 0.
REQ-037 With WIDTH=8 and NUM_IN=5, all channels valid, mode=0 -> out_sel cycles 0..4 and wraps to 0, never reaching 5..7.
